// File: rtl/qpmux_sel_ctrl_pkg.sv
// Shared types and helpers for the QPMUX select sequencer.
package qpmux_pkg;

  typedef enum logic [1:0] {
    SRC_QCLKIN = 2'b00,
    SRC_QHSCK  = 2'b01,
    SRC_GMUXIN = 2'b10,
    SRC_BAD    = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_FIN
  } state_e;

  // Returns {IS1,IS0}; the illegal code maps to 00 so IS0=IS1=1 can never be driven.
  function automatic logic [1:0] src_to_pins(input logic [1:0] src);
    case (src)
      SRC_QHSCK:  return 2'b10;
      SRC_GMUXIN: return 2'b01;
      default:    return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/qpmux_sel_ctrl_if.sv
// Request/completion handshake between the controlling agent and qpmux_sel_ctrl.
interface qpmux_sel_ctrl_if;
  logic       REQ_VALID;
  logic [1:0] REQ_SRC;
  logic       REQ_READY;
  logic       DONE;
  logic       ERR;

  modport master (output REQ_VALID, REQ_SRC, input REQ_READY, DONE, ERR);
  modport slave  (input REQ_VALID, REQ_SRC, output REQ_READY, DONE, ERR);
endinterface

// File: rtl/qpmux_sel_ctrl_dly_cnt.sv
// 8-bit loadable down-counter with zero flag; times both the drain and settle phases.
module qpmux_dly_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/qpmux_sel_ctrl.sv
// QPMUX select sequencer: gates the muxed clock off around every IS0/IS1 change.
// Optional switch counter output SW_CNT enabled by QPMUX_SEL_CTRL_STATS_EN.
module qpmux_sel_ctrl
  import qpmux_pkg::*;
#(
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 3,
  parameter logic [1:0]  RST_SRC    = 2'b00
) (
  input  logic              CLK,
  input  logic              RSTN,
  qpmux_sel_ctrl_if.slave   req,
  output logic              IS0,
  output logic              IS1,
  output logic              GATE_EN,
  output logic [1:0]        CUR_SRC
`ifdef QPMUX_SEL_CTRL_STATS_EN
  ,
  output logic [7:0]        SW_CNT
`endif
);
  localparam logic [1:0] RST_SRC_EFF = (RST_SRC == 2'b11) ? 2'b00 : RST_SRC;
  localparam logic [7:0] DRAIN_LD    = 8'(DRAIN_CYC - 1);
  localparam logic [7:0] SETTLE_LD   = 8'(SETTLE_CYC - 1);

  state_e     state_d, state_q;
  logic [1:0] tgt_d, tgt_q;
  logic [1:0] cur_d, cur_q;
  logic [1:0] pins_d, pins_q;
  logic       gate_d, gate_q;
  logic       ready_d, ready_q;
  logic       done_d, done_q;
  logic       err_d, err_q;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [7:0] cnt_val;

  qpmux_dly_cnt u_dly_cnt (
    .clk      (CLK),
    .rst_n    (RSTN),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cur_d    = cur_q;
    pins_d   = pins_q;
    gate_d   = gate_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.REQ_VALID && ready_q) begin
          tgt_d = req.REQ_SRC;
          if (req.REQ_SRC == SRC_BAD) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end else if (req.REQ_SRC == cur_q) begin
            state_d = ST_FIN;
          end else begin
            state_d  = ST_DRAIN;
            gate_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = DRAIN_LD;
          end
        end
      end
      ST_DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d  = ST_SWITCH;
          cur_d    = tgt_q;
          pins_d   = src_to_pins(tgt_q);
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LD;
        end
      end
      ST_SWITCH: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_FIN;
          gate_d  = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are decoded from the next state so they stay registered.
    done_d  = (state_d == ST_FIN);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      tgt_q   <= RST_SRC_EFF;
      cur_q   <= RST_SRC_EFF;
      pins_q  <= src_to_pins(RST_SRC_EFF);
      gate_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      pins_q  <= pins_d;
      gate_q  <= gate_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign IS1           = pins_q[1];
  assign IS0           = pins_q[0];
  assign GATE_EN       = gate_q;
  assign CUR_SRC       = cur_q;
  assign req.REQ_READY = ready_q;
  assign req.DONE      = done_q;
  assign req.ERR       = err_q;

`ifdef QPMUX_SEL_CTRL_STATS_EN
  logic [7:0] sw_cnt_d, sw_cnt_q;

  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if (state_q == ST_SWITCH && cnt_zero && sw_cnt_q != '1) sw_cnt_d = sw_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) sw_cnt_q <= '0;
    else       sw_cnt_q <= sw_cnt_d;
  end

  assign SW_CNT = sw_cnt_q;
`endif
endmodule

// File: tb/tb_qpmux_sel_ctrl.sv
// Scoreboard bench for qpmux_sel_ctrl; covers SW_CNT when QPMUX_SEL_CTRL_STATS_EN is defined.
module tb_qpmux_sel_ctrl;
  localparam int unsigned D = 4;
  localparam int unsigned S = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       is0, is1, gate;
  logic [1:0] cur;
`ifdef QPMUX_SEL_CTRL_STATS_EN
  logic [7:0]  sw_cnt;
  int unsigned m_sw = 0;
`endif

  always #5 clk = ~clk;

  qpmux_sel_ctrl_if rif ();

  qpmux_sel_ctrl #(.DRAIN_CYC(D), .SETTLE_CYC(S), .RST_SRC(2'b00)) dut (
    .CLK     (clk),
    .RSTN    (rstn),
    .req     (rif),
    .IS0     (is0),
    .IS1     (is1),
    .GATE_EN (gate),
    .CUR_SRC (cur)
`ifdef QPMUX_SEL_CTRL_STATS_EN
    ,
    .SW_CNT  (sw_cnt)
`endif
  );

  typedef struct {
    logic       err;
    logic [1:0] cur;
    int         lat;
    bit         real_sw;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m_cur;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic logic [1:0] pins(input logic [1:0] s);
    return {s == 2'b01, s == 2'b10};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_ready();
    int i = 0;
    while (rif.REQ_READY !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check_eq("ready_wait", {31'd0, rif.REQ_READY}, 1);
  endtask

  task automatic run_req(input logic [1:0] src, input bit intrude);
    exp_t e, g;
    int   n;
    e.err     = (src == 2'b11);
    e.real_sw = !e.err && (src != m_cur);
    e.cur     = e.real_sw ? src : m_cur;
    e.lat     = e.real_sw ? int'(D + S) : 0;
    wait_ready();
    rif.REQ_VALID = 1'b1;
    rif.REQ_SRC   = src;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rif.REQ_VALID = 1'b0;
    rif.REQ_SRC   = 2'($urandom_range(0, 3));
    n = 0;
    while (1) begin
      @(negedge clk);
      if (e.real_sw) begin
        if (n == 0 || n == int'(D + S) - 1) check_eq("gate_low", {31'd0, gate}, 0);
        if (n == int'(D) - 1) check_eq("is_hold", {30'd0, is1, is0}, {30'd0, pins(m_cur)});
        if (n == int'(D))     check_eq("is_new", {30'd0, is1, is0}, {30'd0, pins(src)});
        if (intrude && n == 1) begin
          rif.REQ_VALID = 1'b1;
          rif.REQ_SRC   = 2'b10;
        end
        if (intrude && n == 3) rif.REQ_VALID = 1'b0;
      end else if (n == 0) begin
        check_eq("gate_hold", {31'd0, gate}, 1);
      end
      if (rif.DONE === 1'b1 || n >= 40) break;
      n++;
    end
    g = sb.pop_front();
    check_eq("done_lat", n, g.lat);
    check_eq("err", {31'd0, rif.ERR}, {31'd0, g.err});
    check_eq("cur_src", {30'd0, cur}, {30'd0, g.cur});
    check_eq("is_pins", {30'd0, is1, is0}, {30'd0, pins(g.cur)});
    check_eq("gate_fin", {31'd0, gate}, 1);
    check_eq("ready_fin", {31'd0, rif.REQ_READY}, 0);
`ifdef QPMUX_SEL_CTRL_STATS_EN
    if (g.real_sw && m_sw < 255) m_sw++;
    check_eq("sw_cnt", {24'd0, sw_cnt}, m_sw);
`endif
    @(negedge clk);
    check_eq("done_pulse", {31'd0, rif.DONE}, 0);
    check_eq("err_pulse", {31'd0, rif.ERR}, 0);
    check_eq("ready_back", {31'd0, rif.REQ_READY}, 1);
    m_cur = g.cur;
  endtask

  task automatic reset_in_switch();
    logic [1:0] src;
    int         seen = 0;
    src = (m_cur == 2'b01) ? 2'b10 : 2'b01;
    wait_ready();
    rif.REQ_VALID = 1'b1;
    rif.REQ_SRC   = src;
    @(posedge clk);
    #1;
    rif.REQ_VALID = 1'b0;
    repeat (D + 1) @(negedge clk);
    check_eq("sw_gate_low", {31'd0, gate}, 0);
    check_eq("sw_is_new", {30'd0, is1, is0}, {30'd0, pins(src)});
    #1;
    rstn = 1'b0;
    #1;
    check_eq("rst_is", {30'd0, is1, is0}, 0);
    check_eq("rst_gate", {31'd0, gate}, 1);
    check_eq("rst_ready", {31'd0, rif.REQ_READY}, 1);
    check_eq("rst_cur", {30'd0, cur}, 0);
    check_eq("rst_done", {31'd0, rif.DONE}, 0);
`ifdef QPMUX_SEL_CTRL_STATS_EN
    m_sw = 0;
    check_eq("rst_sw_cnt", {24'd0, sw_cnt}, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rif.DONE === 1'b1) seen++;
    end
    check_eq("no_done_after_rst", seen, 0);
    m_cur = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn          = 1'b0;
    rif.REQ_VALID = 1'b0;
    rif.REQ_SRC   = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("reset_is", {30'd0, is1, is0}, 0);
    check_eq("reset_gate", {31'd0, gate}, 1);
    check_eq("reset_ready", {31'd0, rif.REQ_READY}, 1);
    check_eq("reset_cur", {30'd0, cur}, 0);
    check_eq("reset_done", {31'd0, rif.DONE}, 0);
    check_eq("reset_err", {31'd0, rif.ERR}, 0);
    rstn  = 1'b1;
    m_cur = 2'b00;
    @(negedge clk);

    run_req(2'b01, 1'b0);
    run_req(2'b01, 1'b0);
    run_req(2'b11, 1'b0);
    run_req(2'b10, 1'b1);
    run_req(2'b00, 1'b0);
    run_req(2'b10, 1'b0);
    reset_in_switch();
    run_req(2'b00, 1'b0);
    run_req(2'b01, 1'b0);

`ifdef QPMUX_SEL_CTRL_STATS_EN
    for (int i = 0; i < 300; i++) run_req((m_cur == 2'b01) ? 2'b00 : 2'b01, 1'b0);
    check_eq("sw_cnt_sat", {24'd0, sw_cnt}, 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
